// File: rtl/nes_cpu_bus_if.sv
// nes_cpu_bus_if: 6502-side bus between the CPU (master) and the memory controller (slave).
interface nes_cpu_bus_if;
  logic [15:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        ren;
  logic        wen;
  logic [7:0]  cpu_data_in;
  logic        rdy;
  modport master(output cpu_addr_out, cpu_data_out, ren, wen, input cpu_data_in, rdy);
  modport slave(input cpu_addr_out, cpu_data_out, ren, wen, output cpu_data_in, rdy);
endinterface

// File: rtl/nes_cpu_bus.sv
// nes_cpu_bus: CPU address decode for work RAM, cartridge SRAM, PRG ROM and PPU registers,
// plus the 0x4014 OAM DMA engine that stalls the CPU through rdy.
module nes_cpu_bus #(
  parameter int          RAM_AW   = 11,
  parameter int          SRAM_AW  = 13,
  parameter int          ROM_AW   = 15,
  parameter logic [15:0] DMA_ADDR = 16'h4014
) (
  input  logic              clk,
  input  logic              b_rst,
  nes_cpu_bus_if.slave      bus,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic [2:0]        io_addr,
  output logic [7:0]        io_wdata,
  output logic              io_wen,
  output logic              io_ren,
  input  logic [7:0]        io_rdata
);
  typedef enum logic [1:0] {IDLE, ALIGN, RD, WR} state_t;
  typedef enum logic [2:0] {S_NONE, S_RAM, S_SRAM, S_ROM, S_PPU} src_t;
  state_t state, state_d;
  src_t src, src_d, region;
  logic [7:0] page, idx, hold, ram_q, sram_q, src_data, data_in;
  logic [7:0] ram [2**RAM_AW];
  logic [7:0] sram [2**SRAM_AW];
  logic [15:0] a;
  logic idle, is_ram, is_ppu, is_sram, is_rom, cpu_wr, cpu_rdv, cpu_rd, cpu_rd_d, ppu_wr;
  always_comb begin
    idle     = state == IDLE;
    a        = idle ? bus.cpu_addr_out : {page, idx};
    is_ram   = a[15:13] == 3'd0;
    is_ppu   = a[15:13] == 3'd1;
    is_sram  = a[15:13] == 3'd3;
    is_rom   = a[15];
    cpu_wr   = idle & bus.wen;
    cpu_rdv  = idle & bus.ren & ~bus.wen;
    region   = is_ram ? S_RAM : is_sram ? S_SRAM : is_rom ? S_ROM : is_ppu ? S_PPU : S_NONE;
    // DMA never strobes the PPU; PPU/unmapped DMA sources read as zero
    src_d    = cpu_rdv ? region : (state == RD && region != S_PPU) ? region : S_NONE;
    cpu_rd_d = cpu_rdv && region != S_NONE;
    src_data = src == S_RAM ? ram_q : src == S_SRAM ? sram_q : src == S_ROM ? rom_rdata :
               src == S_PPU ? io_rdata : 8'h00;
    data_in  = cpu_rd ? src_data : hold;
    ppu_wr   = cpu_wr & is_ppu;
    io_ren   = cpu_rdv & is_ppu;
    io_wen   = ppu_wr | (state == WR);
    io_addr  = state == WR ? 3'd4 : (ppu_wr | io_ren) ? a[2:0] : 3'd0;
    io_wdata = state == WR ? src_data : ppu_wr ? bus.cpu_data_out : 8'h00;
    rom_addr = a[ROM_AW-1:0];
    state_d  = state;
    state_d  = state == IDLE ? ((cpu_wr && a == DMA_ADDR) ? ALIGN : IDLE) :
               state == ALIGN ? RD :
               state == RD ? WR :
               (idx == 8'hFF ? IDLE : RD);
  end
  assign bus.cpu_data_in = data_in;
  assign bus.rdy         = idle;
  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state  <= IDLE;
      src    <= S_NONE;
      cpu_rd <= 1'b0;
      hold   <= 8'h00;
      page   <= 8'h00;
      idx    <= 8'h00;
    end else begin
      state  <= state_d;
      src    <= src_d;
      cpu_rd <= cpu_rd_d;
      hold   <= data_in;
      if (idle && state_d == ALIGN) page <= bus.cpu_data_out;
      if (state == WR) idx <= idx + 8'd1;
    end
  end
  // Memories keep their contents across reset
  always_ff @(posedge clk) begin
    if (cpu_wr && is_ram) ram[a[RAM_AW-1:0]] <= bus.cpu_data_out;
    if (cpu_wr && is_sram) sram[a[SRAM_AW-1:0]] <= bus.cpu_data_out;
    ram_q  <= ram[a[RAM_AW-1:0]];
    sram_q <= sram[a[SRAM_AW-1:0]];
  end
endmodule
